hack_memory: RTL and testbench

HACK_MEMORY -- requirements
Module: hack_memory

---
 rtl/hack_memory.sv | 92 +++++++++
 tb/tb_hack_memory.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hack_memory.sv
// hack_memory: Hack data memory (RAM, SCREEN, KBD) with a concurrent screen scanner.
// Ports:
//   clk, reset (async, active-low)
//   addressM/writeM/outM -> inM : CPU data port, combinational read, write on rising edge
//   kbd_strobe/kbd_code/kbd_release : keyboard register load/clear
//   frame_start, vid_valid/vid_ready/vid_addr/vid_word, frame_done : screen readout stream
//   oor_err : sticky flag for writes to KBD/unmapped, only with HACK_MEM_OOR_TRAP_EN defined
module hack_memory (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic        kbd_strobe,
  input  logic [15:0] kbd_code,
  input  logic        kbd_release,
  input  logic        frame_start,
  output logic        vid_valid,
  input  logic        vid_ready,
  output logic [12:0] vid_addr,
  output logic [15:0] vid_word,
  output logic        frame_done,
  output logic        oor_err
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [15:0] r_ram [16384];
  logic [15:0] r_scr [8192];
  logic [15:0] r_kbd, r_vid_word;
  logic [12:0] r_ptr, w_fetch_addr;
  logic        w_fetch;
  logic        w_ram_sel, w_scr_sel, w_kbd_sel;
  assign w_ram_sel = ~addressM[14];
  assign w_scr_sel = addressM[14:13] == 2'b10;
  assign w_kbd_sel = addressM == 15'h6000;
  assign inM = w_ram_sel ? r_ram[addressM[13:0]] :
               w_scr_sel ? r_scr[addressM[12:0]] :
               w_kbd_sel ? r_kbd : 16'h0000;
  always_ff @(posedge clk) begin
    if (writeM && w_ram_sel) r_ram[addressM[13:0]] <= outM;
    if (writeM && w_scr_sel) r_scr[addressM[12:0]] <= outM;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  // The last word's handshake moves to DONE instead of fetching, so the pointer never wraps.
  always_comb begin
    w_next       = r_state;
    w_fetch      = 1'b0;
    w_fetch_addr = r_ptr + 13'd1;
    case (r_state)
      IDLE: if (frame_start) begin
        w_next       = SCAN;
        w_fetch      = 1'b1;
        w_fetch_addr = 13'd0;
      end
      SCAN: if (vid_ready) begin
        if (r_ptr == 13'h1FFF) w_next = DONE;
        else                   w_fetch = 1'b1;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // Fetch samples SCREEN before a same-edge CPU write lands, so the old value is presented.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ptr      <= 13'd0;
      r_vid_word <= 16'h0000;
      r_kbd      <= 16'h0000;
    end else begin
      if (w_fetch) begin
        r_ptr      <= w_fetch_addr;
        r_vid_word <= r_scr[w_fetch_addr];
      end
      r_kbd <= kbd_strobe ? kbd_code : kbd_release ? 16'h0000 : r_kbd;
    end
  assign vid_valid  = r_state == SCAN;
  assign frame_done = r_state == DONE;
  assign vid_addr   = r_ptr;
  assign vid_word   = r_vid_word;
`ifdef HACK_MEM_OOR_TRAP_EN
  logic r_oor;
  always_ff @(posedge clk or negedge reset)
    if (!reset)                                 r_oor <= 1'b0;
    else if (writeM && !w_ram_sel && !w_scr_sel) r_oor <= 1'b1;
  assign oor_err = r_oor;
`else
  assign oor_err = 1'b0;
`endif
endmodule

// File: tb/tb_hack_memory.sv
// tb_hack_memory: directed self-checking bench for hack_memory with a video scoreboard.
module tb_hack_memory;
`ifdef HACK_MEM_OOR_TRAP_EN
  localparam logic OOR_EN = 1'b1;
`else
  localparam logic OOR_EN = 1'b0;
`endif
  typedef struct { logic [12:0] a; logic [15:0] w; } vid_t;
  logic        clk = 0, reset = 0;
  logic [14:0] addressM = 0;
  logic        writeM = 0;
  logic [15:0] outM = 0, inM;
  logic        kbd_strobe = 0, kbd_release = 0;
  logic [15:0] kbd_code = 0;
  logic        frame_start = 0, vid_valid, vid_ready = 0;
  logic [12:0] vid_addr;
  logic [15:0] vid_word;
  logic        frame_done, oor_err;
  vid_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  hack_memory dut (
    .clk(clk), .reset(reset), .addressM(addressM), .writeM(writeM), .outM(outM), .inM(inM),
    .kbd_strobe(kbd_strobe), .kbd_code(kbd_code), .kbd_release(kbd_release),
    .frame_start(frame_start), .vid_valid(vid_valid), .vid_ready(vid_ready),
    .vid_addr(vid_addr), .vid_word(vid_word), .frame_done(frame_done), .oor_err(oor_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic vid_step();
    if (q.size() == 0) chk("vid_extra", {31'd0, vid_valid}, 32'd0);
    else if (!vid_valid) chk("vid_gap", 32'd0, 32'd1);
    else begin
      chk("vid_addr", {19'd0, vid_addr}, {19'd0, q[0].a});
      chk("vid_word", {16'd0, vid_word}, {16'd0, q[0].w});
      if (vid_ready) void'(q.pop_front());
    end
  endtask
  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    addressM = a; outM = d; writeM = 1;
    @(negedge clk);
    writeM = 0;
  endtask
  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    addressM = a;
    #1 chk(tag, {16'd0, inM}, {16'd0, exp});
  endtask
  initial begin
    #1;
    chk("rst_valid", {31'd0, vid_valid}, 32'd0);
    chk("rst_addr", {19'd0, vid_addr}, 32'd0);
    chk("rst_word", {16'd0, vid_word}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_oor", {31'd0, oor_err}, 32'd0);
    rd("rst_kbd", 15'h6000, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1;
    wr(15'h0010, 16'h1234);
    rd("ram_0010", 15'h0010, 16'h1234);
    rd("unmapped_6123", 15'h6123, 16'h0000);
    wr(15'h3FFF, 16'hABCD);
    rd("ram_3fff", 15'h3FFF, 16'hABCD);
    rd("ram_0010_keep", 15'h0010, 16'h1234);
    @(negedge clk);
    kbd_strobe = 1; kbd_code = 16'h0041;
    @(negedge clk);
    kbd_strobe = 0;
    rd("kbd_41", 15'h6000, 16'h0041);
    kbd_strobe = 1; kbd_release = 1; kbd_code = 16'h0042;
    @(negedge clk);
    kbd_strobe = 0; kbd_release = 0;
    rd("kbd_strobe_wins", 15'h6000, 16'h0042);
    kbd_release = 1;
    @(negedge clk);
    kbd_release = 0;
    rd("kbd_release", 15'h6000, 16'h0000);
    wr(15'h6000, 16'hBEEF);
    #1 chk("oor_kbd_write", {31'd0, oor_err}, {31'd0, OOR_EN});
    rd("kbd_unchanged", 15'h6000, 16'h0000);
    wr(15'h7FFF, 16'h5555);
    rd("unmapped_7fff", 15'h7FFF, 16'h0000);
    chk("oor_sticky", {31'd0, oor_err}, {31'd0, OOR_EN});
    for (int i = 0; i < 8192; i++) begin
      @(negedge clk);
      addressM = 15'h4000 + 15'(i); outM = 16'(i); writeM = 1;
    end
    @(negedge clk);
    writeM = 0;
    rd("scr_5fff", 15'h5FFF, 16'h1FFF);
    rd("ram_not_hit", 15'h0010, 16'h1234);
    // full frame at one word per cycle
    for (int i = 0; i < 8192; i++) q.push_back('{a: 13'(i), w: 16'(i)});
    frame_start = 1; vid_ready = 1;
    for (int c = 0; c < 9000 && q.size() > 0; c++) begin
      @(negedge clk);
      frame_start = 0;
      #1 vid_step();
    end
    chk("frame_remaining", q.size(), 0);
    @(negedge clk);
    #1 chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("done_valid", {31'd0, vid_valid}, 32'd0);
    @(negedge clk);
    #1 chk("done_single", {31'd0, frame_done}, 32'd0);
    chk("idle_valid", {31'd0, vid_valid}, 32'd0);
    // stall at word 7 with a CPU write to it, then reset mid-frame at word 100
    for (int i = 0; i < 8192; i++) q.push_back('{a: 13'(i), w: 16'(i)});
    frame_start = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      frame_start = 0;
      #1;
      if (vid_addr == 13'd7) vid_ready = 0;
      vid_step();
      if (!vid_ready) break;
    end
    chk("stall_reached", {31'd0, vid_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin addressM = 15'h4007; outM = 16'hFFFF; writeM = 1; frame_start = 1; end
      if (k == 1) begin writeM = 0; frame_start = 0; end
      #1;
      if (k == 4) vid_ready = 1;
      vid_step();
    end
    rd("scr_4007_new", 15'h4007, 16'hFFFF);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (vid_addr == 13'd100) break;
      vid_step();
    end
    chk("reach_100", {19'd0, vid_addr}, 32'd100);
    reset = 0;
    #1 chk("abort_valid", {31'd0, vid_valid}, 32'd0);
    chk("abort_addr", {19'd0, vid_addr}, 32'd0);
    chk("abort_done", {31'd0, frame_done}, 32'd0);
    chk("abort_oor", {31'd0, oor_err}, 32'd0);
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("no_done_after_abort", {31'd0, frame_done}, 32'd0);
    end
    rd("scr_kept_over_reset", 15'h4007, 16'hFFFF);
    q.delete();
    q.push_back('{a: 13'd0, w: 16'd0});
    q.push_back('{a: 13'd1, w: 16'd1});
    frame_start = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      frame_start = 0;
      #1 vid_step();
    end
    chk("restart_consumed", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
